// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch front end with prefetch queue and APB read master
// Optional build macro: FETCHQ_ERR_EN (per-entry fault bit on err_o, halt after a faulted read).

module apb_controller_sbm #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [31:0]       rdata_o,
`ifdef FETCHQ_ERR_EN
  output logic              err_o,
`endif
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       prdata,
`ifdef FETCHQ_ERR_EN
  input  logic              pslverr,
`endif
  input  logic              pready
);
  assign pwrite  = 1'b0;
  assign valid_o = psel && penable && pready;
  assign rdata_o = prdata;
`ifdef FETCHQ_ERR_EN
  assign err_o   = pslverr;
`endif

  // A start in the completing access cycle chains straight into the next setup phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      paddr   <= '0;
    end else if (start_i) begin
      psel    <= 1'b1;
      penable <= 1'b0;
      paddr   <= addr_i;
    end else if (psel && !penable) begin
      penable <= 1'b1;
    end else if (valid_o) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end
endmodule

module fetch_queue_unit #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] INIT_PC = '0,
  parameter int                DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_psel,
  output logic                       imem_penable,
  output logic                       imem_pwrite,
  output logic [ADDR_W-1:0]          imem_paddr,
  input  logic [31:0]                imem_prdata,
  input  logic                       imem_pready,
`ifdef FETCHQ_ERR_EN
  input  logic                       imem_pslverr,
`endif
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [31:0]                inst_o,
  output logic [ADDR_W-1:0]          pc_o,
`ifdef FETCHQ_ERR_EN
  output logic                       err_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DISCARD
`ifdef FETCHQ_ERR_EN
    , ST_HALT
`endif
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [31:0]       mem_inst [DEPTH];

  logic              ctl_valid;
  logic [31:0]       ctl_rdata;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              pop;
  logic              push;
  logic [CW-1:0]     count_after_pop;
  logic [CW-1:0]     count_next;
  logic [ADDR_W-1:0] pc_plus4;
  logic              fault;

`ifdef FETCHQ_ERR_EN
  logic              ctl_err;
  logic              mem_err [DEPTH];
  assign fault = ctl_valid && ctl_err;
  assign err_o = mem_err[rd_ptr];
`else
  assign fault = 1'b0;
`endif

  apb_controller_sbm #(.ADDR_W(ADDR_W)) u_ctl (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .addr_i  (start_addr),
    .valid_o (ctl_valid),
    .rdata_o (ctl_rdata),
`ifdef FETCHQ_ERR_EN
    .err_o   (ctl_err),
    .pslverr (imem_pslverr),
`endif
    .psel    (imem_psel),
    .penable (imem_penable),
    .pwrite  (imem_pwrite),
    .paddr   (imem_paddr),
    .prdata  (imem_prdata),
    .pready  (imem_pready)
  );

  assign valid_o         = (count != '0) && !redirect_i;
  assign inst_o          = mem_inst[rd_ptr];
  assign pc_o            = mem_pc[rd_ptr];
  assign count_o         = count;
  assign pop             = valid_o && ready_i;
  assign push            = ctl_valid && (state == ST_WAIT) && !redirect_i;
  assign count_after_pop = count - CW'(pop);
  assign count_next      = count_after_pop + CW'(push);
  assign pc_plus4        = fetch_pc + ADDR_W'(4);

  always_comb begin
    start      = 1'b0;
    start_addr = fetch_pc;
    if (!redirect_i) begin
      case (state)
        ST_IDLE: start = (count_after_pop < CW'(DEPTH));
        ST_WAIT: begin
          if (ctl_valid && !fault && (count_next < CW'(DEPTH))) begin
            start      = 1'b1;
            start_addr = pc_plus4;
          end
        end
        default: start = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fetch_pc <= INIT_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
`ifdef FETCHQ_ERR_EN
        mem_err[i]  <= 1'b0;
`endif
      end
    end else if (redirect_i) begin
      // An in-flight APB read cannot be aborted, so its data is waited out and dropped.
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fetch_pc <= redirect_pc_i & ~ADDR_W'(3);
      case (state)
        ST_WAIT, ST_DISCARD: state <= ctl_valid ? ST_IDLE : ST_DISCARD;
        default:             state <= ST_IDLE;
      endcase
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= fetch_pc;
        mem_inst[wr_ptr] <= ctl_rdata;
`ifdef FETCHQ_ERR_EN
        mem_err[wr_ptr]  <= ctl_err;
`endif
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      case (state)
        ST_IDLE: if (start) state <= ST_WAIT;
        ST_WAIT: begin
          if (ctl_valid) begin
            fetch_pc <= pc_plus4;
`ifdef FETCHQ_ERR_EN
            if (fault) state <= ST_HALT;
            else
`endif
            if (!start) state <= ST_IDLE;
          end
        end
        ST_DISCARD: if (ctl_valid) state <= ST_IDLE;
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed plus random bench for fetch_queue_unit against a stream model
// Exercises the FETCHQ_ERR_EN fault path when that macro is defined.

module tb_fetch_queue_unit;
  localparam int          ADDR_W  = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] INIT_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_psel, imem_penable, imem_pwrite;
  logic [31:0] imem_paddr, imem_prdata;
  logic        imem_pready;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] inst_o, pc_o;
  logic [2:0]  count_o;
`ifdef FETCHQ_ERR_EN
  logic        imem_pslverr;
  logic        err_o;
`endif

  int          checks = 0;
  int          errors = 0;
  int          wait_states = 0;
  int          wait_cnt;
  logic [31:0] err_addr = 32'h1;
  logic [31:0] exp_pc;
  int          accepted;
  bit          psel_seen;

  always #5 clk = ~clk;

  fetch_queue_unit #(.ADDR_W(ADDR_W), .INIT_PC(INIT_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_psel     (imem_psel),
    .imem_penable  (imem_penable),
    .imem_pwrite   (imem_pwrite),
    .imem_paddr    (imem_paddr),
    .imem_prdata   (imem_prdata),
    .imem_pready   (imem_pready),
`ifdef FETCHQ_ERR_EN
    .imem_pslverr  (imem_pslverr),
    .err_o         (err_o),
`endif
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .count_o       (count_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE_0000;
  endfunction

  // APB slave: data is a hash of the address, wait_states extra access cycles.
  assign imem_prdata = mem_word(imem_paddr);
  assign imem_pready = (wait_cnt >= wait_states);
`ifdef FETCHQ_ERR_EN
  assign imem_pslverr = imem_psel && imem_penable && (imem_paddr == err_addr);
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (imem_psel && imem_penable && !imem_pready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check the visible head against the expected stream, then advance the model.
  task automatic cycle();
    #1;
    if (redirect_i) begin
      check("valid_masked", valid_o, 1'b0);
    end else if (valid_o) begin
      check("pc_o", pc_o, exp_pc);
      check("inst_o", inst_o, mem_word(exp_pc));
`ifdef FETCHQ_ERR_EN
      check("err_o", err_o, exp_pc == err_addr);
`endif
      if (ready_i) begin
        exp_pc   = exp_pc + 32'd4;
        accepted = accepted + 1;
      end
    end
    if (redirect_i) exp_pc = redirect_pc_i & ~32'h3;
    if (imem_psel) psel_seen = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;
    @(negedge clk);
    #1;
    check("rst_valid", valid_o, 1'b0);
    check("rst_count", count_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_psel", imem_psel, 1'b0);
    rst_n    = 1'b1;
    exp_pc   = INIT_PC;
    accepted = 0;
  endtask

  task automatic run_until_accepted(input int n, input int budget);
    int target = accepted + n;
    for (int i = 0; i < budget && accepted < target; i++) cycle();
    check("accept_timeout", accepted >= target, 1'b1);
  endtask

  task automatic wait_setup(input int budget);
    int i = 0;
    cycle();
    while (!(imem_psel && !imem_penable) && i < budget) begin
      cycle();
      i++;
    end
    check("setup_timeout", imem_psel && !imem_penable, 1'b1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_i = 1'b1;
    redirect_pc_i = target;
    cycle();
    redirect_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;
    exp_pc = INIT_PC; accepted = 0; psel_seen = 1'b0;

    // sequential stream from INIT_PC, zero-wait slave
    do_reset();
    ready_i = 1'b1;
    run_until_accepted(3, 40);

    // back-pressure fills the queue, fetch stalls, then resumes at 0x110
    do_reset();
    for (int i = 0; i < 20; i++) cycle();
    psel_seen = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("full_count", count_o, DEPTH);
    check("full_no_psel", psel_seen, 1'b0);
    check("full_head_pc", pc_o, 32'h100);
    ready_i = 1'b1;
    wait_setup(20);
    check("resume_addr", imem_paddr, 32'h110);
    run_until_accepted(5, 60);

    // redirect while a slow read is outstanding
    do_reset();
    ready_i = 1'b1;
    wait_states = 3;
    for (int i = 0; i < 60 && !(imem_psel && imem_penable && !imem_pready && accepted > 0); i++) cycle();
    check("wait_phase_found", imem_psel && imem_penable && !imem_pready, 1'b1);
    do_redirect(32'h2000);
    check("discard_count", count_o, 0);
    check("discard_valid", valid_o, 1'b0);
    check("discard_holds_psel", imem_psel, 1'b1);
    wait_setup(20);
    check("discard_next_addr", imem_paddr, 32'h2000);
    run_until_accepted(2, 60);

    // redirect in the same cycle as read completion
    do_reset();
    ready_i = 1'b1;
    wait_states = 1;
    for (int i = 0; i < 40 && !(imem_psel && imem_penable && imem_pready && accepted > 0); i++) cycle();
    check("complete_found", imem_psel && imem_penable && imem_pready, 1'b1);
    do_redirect(32'h3000);
    check("nodiscard_psel", imem_psel, 1'b0);
    check("nodiscard_count", count_o, 0);
    cycle();
    check("nodiscard_start", imem_psel, 1'b1);
    check("nodiscard_addr", imem_paddr, 32'h3000);
    run_until_accepted(2, 40);

    // wrap at the top of the address space, unaligned target
    wait_states = 0;
    do_redirect(32'hFFFF_FFFC);
    run_until_accepted(2, 40);
    check("wrap_model", exp_pc, 32'h4);
    do_redirect(32'h2003);
    run_until_accepted(1, 40);

`ifdef FETCHQ_ERR_EN
    // faulted read halts fetching until a redirect
    do_reset();
    err_addr = 32'h108;
    ready_i = 1'b1;
    run_until_accepted(3, 60);
    psel_seen = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("halt_no_psel", psel_seen, 1'b0);
    check("halt_empty", valid_o, 1'b0);
    do_redirect(32'h400);
    wait_setup(20);
    check("halt_resume_addr", imem_paddr, 32'h400);
    run_until_accepted(2, 40);
    err_addr = 32'h1;
`endif

    // random back-pressure, wait states and redirects against the stream model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      ready_i    = ($urandom_range(0, 9) < 7);
      redirect_i = ($urandom_range(0, 31) == 0);
      redirect_pc_i = $urandom_range(0, 1) ? $urandom : 32'h1000 + $urandom_range(0, 255);
      if (!imem_psel) wait_states = $urandom_range(0, 3);
      check("count_bound", count_o <= DEPTH, 1'b1);
      cycle();
    end
    redirect_i = 1'b0;
    ready_i = 1'b1;
    run_until_accepted(2, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
